// File: rtl/digit_serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
// No logic and no latency; holds the FSM encoding, the result flags and parameter checks.
package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } flags_t;

  function automatic bit chunk_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

  // A 1-chunk operand still needs a 1-bit index register.
  function automatic int idx_width(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/digit_serial_adder_ripple_add_n.sv
// N-bit combinational ripple-carry adder built from full-adder cells.
// Zero latency, no flow control; c_msb is the carry into bit N-1 for overflow detection.
module ripple_add_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout  = c[N];
  assign c_msb = c[N - 1];

endmodule

// File: rtl/digit_serial_adder.sv
// Handshaked WIDTH-bit add/subtract, CHUNK bits per cycle LSB first via a registered carry.
// Latency WIDTH/CHUNK cycles; result held in DONE until out_ready, operands taken only in IDLE.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = idx_width(NCHUNK);

  if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_chunk
    $fatal(1, "digit_serial_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_nxt;
  logic             carry_q;
  logic [IW-1:0]    idx_q;
  flags_t           flags_q;
  logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
  logic             c_out, c_msb, last;

  assign last = (idx_q == IW'(NCHUNK - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Constant-index mux keeps every part-select in range for any NCHUNK.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IW'(i)) begin
        a_chunk = a_q[i*CHUNK +: CHUNK];
        b_chunk = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  ripple_add_n #(.N(CHUNK)) u_chunk_add (
    .a     (a_chunk),
    .b     (b_chunk),
    .cin   (carry_q),
    .sum   (s_chunk),
    .cout  (c_out),
    .c_msb (c_msb)
  );

  always_comb begin
    sum_nxt = sum_q;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IW'(i)) sum_nxt[i*CHUNK +: CHUNK] = s_chunk;
    end
  end

  // Subtraction is A + ~B + ~borrow, so invert once at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      flags_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? ~cin : cin;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_q   <= sum_nxt;
          carry_q <= c_out;
          idx_q   <= idx_q + 1'b1;
          if (last) begin
            flags_q.cout <= c_out;
            flags_q.ovf  <= c_out ^ c_msb;
            flags_q.zero <= (sum_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = flags_q.cout;
  assign ovf  = flags_q.ovf;
  assign zero = flags_q.zero;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder at CHUNK = 4, 16 and 1 (WIDTH = 16) against an integer-arithmetic model.
module tb_digit_serial_adder;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid_s [3];
  logic         in_ready_s [3];
  logic         sub_s      [3];
  logic         cin_s      [3];
  logic         out_valid_s[3];
  logic         out_ready_s[3];
  logic         cout_s     [3];
  logic         ovf_s      [3];
  logic         zero_s     [3];
  logic [W-1:0] a_s        [3];
  logic [W-1:0] b_s        [3];
  logic [W-1:0] sum_s      [3];

  int compared   = 0;
  int mismatched = 0;

  // d0: CHUNK 4, d1: CHUNK 16, d2: CHUNK 1
  for (genvar g = 0; g < 3; g++) begin : g_dut
    digit_serial_adder #(
      .WIDTH (W),
      .CHUNK ((g == 0) ? 4 : ((g == 1) ? 16 : 1))
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_s[g]),
      .in_ready  (in_ready_s[g]),
      .a         (a_s[g]),
      .b         (b_s[g]),
      .sub       (sub_s[g]),
      .cin       (cin_s[g]),
      .out_valid (out_valid_s[g]),
      .out_ready (out_ready_s[g]),
      .sum       (sum_s[g]),
      .cout      (cout_s[g]),
      .ovf       (ovf_s[g]),
      .zero      (zero_s[g])
    );
  end

  function automatic int nchunk_of(input int d);
    return (d == 0) ? 4 : ((d == 1) ? 1 : 16);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Result computed as plain signed/unsigned integer arithmetic.
  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                       input logic cv, output logic [W-1:0] s, output logic co,
                       output logic ov, output logic z);
    int ua, ub, sa, sb, ur, sr;
    ua = int'({16'h0000, av});
    ub = int'({16'h0000, bv});
    sa = int'($signed(av));
    sb = int'($signed(bv));
    if (!sv) begin
      ur = ua + ub + int'(cv);
      sr = sa + sb + int'(cv);
      co = (ur > 65535);
    end else begin
      ur = ua - ub - int'(cv);
      sr = sa - sb - int'(cv);
      co = (ur >= 0);
    end
    s  = ur[W-1:0];
    ov = (sr > 32767) || (sr < -32768);
    z  = (s == '0);
  endtask

  // Issues one op, measures accept-to-out_valid latency, checks the result during DONE.
  task automatic run_op(input int d, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic sv, input logic cv);
    logic [W-1:0] es;
    logic eco, eov, ez;
    int n, lat;
    model(av, bv, sv, cv, es, eco, eov, ez);
    @(negedge clk);
    a_s[d] = av; b_s[d] = bv; sub_s[d] = sv; cin_s[d] = cv; in_valid_s[d] = 1'b1;
    n = 0;
    while (!in_ready_s[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid_s[d] = 1'b0;
    a_s[d] = 16'($urandom); b_s[d] = 16'($urandom);
    sub_s[d] = 1'($urandom); cin_s[d] = 1'($urandom);
    lat = 0;
    while (!out_valid_s[d] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check($sformatf("d%0d latency", d), 32'(lat), 32'(nchunk_of(d)));
    check($sformatf("d%0d sum %h%s%h", d, av, sv ? "-" : "+", bv), 32'(sum_s[d]), 32'(es));
    check($sformatf("d%0d cout", d), 32'(cout_s[d]), 32'(eco));
    check($sformatf("d%0d ovf", d), 32'(ovf_s[d]), 32'(eov));
    check($sformatf("d%0d zero", d), 32'(zero_s[d]), 32'(ez));
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] corners [4];
    corners = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000};
    if ($urandom_range(3) == 0) return corners[$urandom_range(3)];
    return 16'($urandom);
  endfunction

  initial begin
    int vcount;
    for (int d = 0; d < 3; d++) begin
      in_valid_s[d] = 1'b0; out_ready_s[d] = 1'b1;
      a_s[d] = '0; b_s[d] = '0; sub_s[d] = 1'b0; cin_s[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d reset in_ready", d), 32'(in_ready_s[d]), 32'd1);
      check($sformatf("d%0d reset out_valid", d), 32'(out_valid_s[d]), 32'd0);
      check($sformatf("d%0d reset sum", d), 32'(sum_s[d]), 32'd0);
      check($sformatf("d%0d reset flags", d), 32'({cout_s[d], ovf_s[d], zero_s[d]}), 32'd0);
    end

    for (int d = 0; d < 3; d++) begin
      run_op(d, 16'h1234, 16'h0FFF, 1'b0, 1'b0);
      run_op(d, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      run_op(d, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
      run_op(d, 16'h0005, 16'h0007, 1'b1, 1'b0);
      run_op(d, 16'h8000, 16'h0001, 1'b1, 1'b0);
      run_op(d, 16'h0010, 16'h0000, 1'b1, 1'b1);
    end

    // Result stays on the outputs once back in IDLE.
    @(posedge clk);
    #1;
    check("idle out_valid", 32'(out_valid_s[0]), 32'd0);
    check("idle in_ready", 32'(in_ready_s[0]), 32'd1);
    check("idle sum held", 32'(sum_s[0]), 32'h000F);

    // Backpressure on d0.
    out_ready_s[0] = 1'b0;
    run_op(0, 16'h1234, 16'h0FFF, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid_s[0] = 1'($urandom); a_s[0] = 16'($urandom); b_s[0] = 16'($urandom);
      @(posedge clk);
      #1;
      check("bp out_valid", 32'(out_valid_s[0]), 32'd1);
      check("bp in_ready", 32'(in_ready_s[0]), 32'd0);
      check("bp sum", 32'(sum_s[0]), 32'h2233);
      check("bp flags", 32'({cout_s[0], ovf_s[0], zero_s[0]}), 32'd0);
    end
    @(negedge clk);
    out_ready_s[0] = 1'b1;
    in_valid_s[0] = 1'b1; a_s[0] = 16'h0003; b_s[0] = 16'h0004; sub_s[0] = 1'b0; cin_s[0] = 1'b0;
    @(posedge clk);
    #1;
    check("release in_ready", 32'(in_ready_s[0]), 32'd1);
    check("release out_valid", 32'(out_valid_s[0]), 32'd0);
    check("release sum kept", 32'(sum_s[0]), 32'h2233);
    @(posedge clk);
    #1;
    check("next accepted", 32'(in_ready_s[0]), 32'd0);
    in_valid_s[0] = 1'b0;
    vcount = 0;
    while (!out_valid_s[0] && vcount < 40) begin
      @(posedge clk);
      #1;
      vcount++;
    end
    check("next latency", 32'(vcount), 32'd4);
    check("next sum", 32'(sum_s[0]), 32'h0007);

    // Reset in the second RUN cycle of d0.
    @(negedge clk);
    a_s[0] = 16'h1234; b_s[0] = 16'h0FFF; sub_s[0] = 1'b0; cin_s[0] = 1'b0; in_valid_s[0] = 1'b1;
    vcount = 0;
    while (!in_ready_s[0] && vcount < 50) begin
      @(negedge clk);
      vcount++;
    end
    @(posedge clk);
    #1;
    in_valid_s[0] = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d arst sum", d), 32'(sum_s[d]), 32'd0);
      check($sformatf("d%0d arst flags", d), 32'({cout_s[d], ovf_s[d], zero_s[d]}), 32'd0);
      check($sformatf("d%0d arst out_valid", d), 32'(out_valid_s[d]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid_s[0]) vcount++;
    end
    check("no out_valid after arst", 32'(vcount), 32'd0);
    run_op(0, 16'h0001, 16'h0001, 1'b0, 1'b0);

    for (int i = 0; i < 15; i++) begin
      for (int d = 0; d < 3; d++) begin
        run_op(d, pick_operand(), pick_operand(), 1'($urandom), 1'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
